// File: rtl/hack_pkg.sv
// Shared Hack instruction field positions, ALU control encoding and the ALU function.
// The ALU is a pure function, so both the core and any future bench model share one definition.
package hack_pkg;

   localparam int DEF_ADDR_W = 15;

   localparam int IS_C    = 15;
   localparam int A_BIT   = 12;
   localparam int COMP_HI = 11;
   localparam int COMP_LO = 6;
   localparam int DEST_A  = 5;
   localparam int DEST_D  = 4;
   localparam int DEST_M  = 3;
   localparam int J_LT    = 2;
   localparam int J_EQ    = 1;
   localparam int J_GT    = 0;

   // Field order matches instruction bits 11..6, so a direct cast decodes the comp field.
   typedef struct packed {
      logic zx;
      logic nx;
      logic zy;
      logic ny;
      logic f;
      logic no;
   } alu_ctl_t;

   typedef struct packed {
      logic [15:0] out;
      logic        zr;
      logic        ng;
   } alu_res_t;

   function automatic alu_res_t alu(input logic [15:0] x_in, input logic [15:0] y_in,
                                    input alu_ctl_t ctl);
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] r;
      alu_res_t    res;
      x = ctl.zx ? 16'h0000 : x_in;
      x = ctl.nx ? ~x : x;
      y = ctl.zy ? 16'h0000 : y_in;
      y = ctl.ny ? ~y : y;
      r = ctl.f ? (x + y) : (x & y);
      r = ctl.no ? ~r : r;
      res.out = r;
      res.zr  = (r == 16'h0000);
      res.ng  = r[15];
      return res;
   endfunction

endpackage

// File: rtl/hack_cpu_program_counter.sv
// Program counter: holds the fetch address; reset beats load, load beats increment.
// Increment wraps naturally at the top of the address space.
module program_counter #(
   parameter int                ADDR_W   = 15,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] in,
   output logic [ADDR_W-1:0] out
);

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         out <= RESET_PC;
      end else if (load) begin
         out <= in;
      end else begin
         out <= out + 1'b1;
      end
   end

endmodule

// File: rtl/hack_cpu.sv
// Single-cycle Hack CPU core: owns A, D and PC, decodes A/C instructions,
// drives data RAM and evaluates jumps from the ALU flags.
module hack_cpu
   import hack_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [15:0]       instruction,
   input  logic [15:0]       inM,
   output logic [15:0]       outM,
   output logic              writeM,
   output logic [ADDR_W-1:0] addressM,
   output logic [ADDR_W-1:0] pc
);

   logic [15:0] a_reg;
   logic [15:0] d_reg;
   logic        is_c;
   logic [15:0] y_op;
   alu_ctl_t    ctl;
   alu_res_t    res;
   logic        jump;
   logic        unused_bits;

   // Bits 14:13 of a C-instruction carry no meaning.
   assign unused_bits = ^instruction[14:13];

   assign is_c = instruction[IS_C];
   assign ctl  = alu_ctl_t'(instruction[COMP_HI:COMP_LO]);

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      y_op = a_reg;
      if (instruction[A_BIT]) begin
         y_op = inM;
      end
      res = alu(d_reg, y_op, ctl);
   end

   assign outM     = res.out;
   assign writeM   = is_c & instruction[DEST_M] & ~reset;
   assign addressM = a_reg[ADDR_W-1:0];

   assign jump = is_c & ((instruction[J_LT] & res.ng) |
                         (instruction[J_EQ] & res.zr) |
                         (instruction[J_GT] & ~res.zr & ~res.ng));

   always_ff @(posedge clock) begin
      if (reset) begin
         a_reg <= 16'h0000;
         d_reg <= 16'h0000;
      end else if (!is_c) begin
         a_reg <= instruction;
      end else begin
         if (instruction[DEST_A]) begin
            a_reg <= res.out;
         end
         if (instruction[DEST_D]) begin
            d_reg <= res.out;
         end
      end
   end

   // Jump target is the pre-edge A, even when this instruction also rewrites A.
   program_counter #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clock (clock),
      .reset (reset),
      .load  (jump),
      .in    (a_reg[ADDR_W-1:0]),
      .out   (pc)
   );

endmodule

// File: tb/tb_hack_cpu.sv
// Self-checking bench for hack_cpu: a table of instruction steps with expected
// combinational outputs and post-edge pc/addressM, checked through a scoreboard queue.
module tb_hack_cpu;

   logic        clock;
   logic        reset;
   logic [15:0] instruction;
   logic [15:0] inM;
   logic [15:0] outM;
   logic        writeM;
   logic [14:0] addressM;
   logic [14:0] pc;

   int n_compared   = 0;
   int n_mismatched = 0;

   typedef struct {
      logic        rst;
      logic [15:0] instr;
      logic [15:0] in_m;
      logic        chk_out;
      logic [15:0] exp_out;
      logic        exp_wr;
      logic [14:0] exp_pc;
      logic [14:0] exp_addr;
   } step_t;

   step_t vec[$];
   step_t sb[$];

   hack_cpu #(
      .ADDR_W   (15),
      .RESET_PC (15'h0000)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .instruction (instruction),
      .inM         (inM),
      .outM        (outM),
      .writeM      (writeM),
      .addressM    (addressM),
      .pc          (pc)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic [15:0] instr, input logic [15:0] in_m,
                      input logic chk_out, input logic [15:0] exp_out, input logic exp_wr,
                      input logic [14:0] exp_pc, input logic [14:0] exp_addr);
      step_t s;
      s.rst = rst; s.instr = instr; s.in_m = in_m; s.chk_out = chk_out;
      s.exp_out = exp_out; s.exp_wr = exp_wr; s.exp_pc = exp_pc; s.exp_addr = exp_addr;
      vec.push_back(s);
   endtask

   initial begin
      step_t s;
      step_t e;
      //   rst instr     inM    chk out      wr  pc        addr
      add(1, 16'hEA87, 16'h0, 0, 16'h0000, 0, 15'd0,    15'd0);    // reset held with 0;JMP
      add(1, 16'hEA87, 16'h0, 0, 16'h0000, 0, 15'd0,    15'd0);
      add(0, 16'hE308, 16'h0, 1, 16'h0000, 1, 15'd1,    15'd0);    // M=D shows D cleared
      add(0, 16'h0015, 16'h0, 0, 16'h0000, 0, 15'd2,    15'd21);   // @21
      add(0, 16'hEC10, 16'h0, 1, 16'd21,   0, 15'd3,    15'd21);   // D=A
      add(0, 16'hE090, 16'h0, 1, 16'd42,   0, 15'd4,    15'd21);   // D=D+A
      add(0, 16'hE308, 16'h0, 1, 16'd42,   1, 15'd5,    15'd21);   // M=D
      add(0, 16'h0005, 16'h0, 0, 16'h0000, 0, 15'd6,    15'd5);
      add(0, 16'hEC10, 16'h0, 1, 16'd5,    0, 15'd7,    15'd5);    // D=5
      add(0, 16'h0064, 16'h0, 0, 16'h0000, 0, 15'd8,    15'd100);
      add(0, 16'hE301, 16'h0, 1, 16'd5,    0, 15'd100,  15'd100);  // D;JGT taken
      add(0, 16'h0000, 16'h0, 0, 16'h0000, 0, 15'd101,  15'd0);
      add(0, 16'hEC10, 16'h0, 1, 16'd0,    0, 15'd102,  15'd0);    // D=0
      add(0, 16'h0064, 16'h0, 0, 16'h0000, 0, 15'd103,  15'd100);
      add(0, 16'hE301, 16'h0, 1, 16'd0,    0, 15'd104,  15'd100);  // D;JGT not taken (zero)
      add(0, 16'hEE90, 16'h0, 1, 16'hFFFF, 0, 15'd105,  15'd100);  // D=-1
      add(0, 16'hE301, 16'h0, 1, 16'hFFFF, 0, 15'd106,  15'd100);  // D;JGT not taken (negative)
      add(0, 16'hF090, 16'h3, 1, 16'd2,    0, 15'd107,  15'd100);  // D=D+M with M=3
      add(0, 16'h0007, 16'h0, 0, 16'h0000, 0, 15'd108,  15'd7);
      add(0, 16'hEC27, 16'h0, 1, 16'd7,    0, 15'd7,    15'd7);    // A=A;JMP
      add(0, 16'hEDE7, 16'h0, 1, 16'd8,    0, 15'd7,    15'd8);    // A=A+1;JMP uses old A
      add(0, 16'h7FFF, 16'h0, 0, 16'h0000, 0, 15'd8,    15'h7FFF);
      add(0, 16'hEA87, 16'h0, 1, 16'h0000, 0, 15'h7FFF, 15'h7FFF); // 0;JMP to top
      add(0, 16'h0032, 16'h0, 0, 16'h0000, 0, 15'd0,    15'd50);   // wrap, A=50
      add(1, 16'hEA87, 16'h0, 0, 16'h0000, 0, 15'd0,    15'd0);    // reset discards jump to 50
      add(1, 16'hE308, 16'h0, 0, 16'h0000, 0, 15'd0,    15'd0);    // writeM blocked in reset
      add(0, 16'hE308, 16'h0, 1, 16'h0000, 1, 15'd1,    15'd0);    // D cleared again

      reset = 1'b1;
      instruction = 16'h0000;
      inM = 16'h0000;

      for (int i = 0; i < vec.size(); i++) begin
         s = vec[i];
         reset = s.rst;
         instruction = s.instr;
         inM = s.in_m;
         sb.push_back(s);
         #1;
         e = sb[0];
         check($sformatf("step%0d writeM", i), {31'd0, writeM}, {31'd0, e.exp_wr});
         if (e.chk_out) begin
            check($sformatf("step%0d outM", i), {16'd0, outM}, {16'd0, e.exp_out});
         end
         @(posedge clock);
         #2;
         e = sb.pop_front();
         check($sformatf("step%0d pc", i), {17'd0, pc}, {17'd0, e.exp_pc});
         check($sformatf("step%0d addressM", i), {17'd0, addressM}, {17'd0, e.exp_addr});
      end

      check("scoreboard drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
